// File: rtl/man_link_scheduler_if.sv
// Requester handshakes and encoder/decoder signals of the Manchester link scheduler.
// The master modport is the scheduler side; the slave modport is the requester/codec side.
interface man_link_scheduler_if;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic [7:0] enc_data;
    logic       enc_start;
    logic       enc_busy;
    logic       dec_valid;
    logic [7:0] dec_data;

    modport master (
        input  req0_valid, req0_data, req1_valid, req1_data,
        input  enc_busy, dec_valid, dec_data,
        output req0_ready, req1_ready, enc_data, enc_start
    );

    modport slave (
        output req0_valid, req0_data, req1_valid, req1_data,
        output enc_busy, dec_valid, dec_data,
        input  req0_ready, req1_ready, enc_data, enc_start
    );
endinterface

// File: rtl/man_link_scheduler.sv
// Arbitrates two byte requesters and runs the encode / decode / verify / retry loop per byte.
// Build option: define MAN_LINK_ROUND_ROBIN_EN for round-robin arbitration (fixed priority otherwise).
module man_link_scheduler #(
    parameter int MAX_RETRY    = 3,
    parameter int TIMEOUT_BITS = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    man_link_scheduler_if.master link,
    input  logic [31:0]          divide_freq,
    output logic                 done_ok,
    output logic                 done_err,
    output logic                 grant_src,
    output logic [1:0]           retry_cnt,
    output logic [7:0]           err_count,
    output logic [2:0]           state_out
);
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GRANT   = 3'd1,
        ST_START   = 3'd2,
        ST_TX_WAIT = 3'd3,
        ST_RX_WAIT = 3'd4,
        ST_CHECK   = 3'd5,
        ST_DONE    = 3'd6,
        ST_FAIL    = 3'd7
    } state_t;

    localparam logic [1:0] MAX_RETRY_C      = 2'(MAX_RETRY);
    localparam logic [7:0] TIMEOUT_BITS_C   = 8'(TIMEOUT_BITS);
    localparam logic [7:0] BUSY_WAIT_BITS_C = 8'd4;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [7:0]  enc_data_r;
    logic        enc_start_r;
    logic        req0_ready_r;
    logic        req1_ready_r;
    logic        done_ok_r;
    logic        done_err_r;
    logic        grant_src_r;
    logic [1:0]  retry_cnt_r;
    logic [7:0]  err_count_r;
    logic [31:0] period_r;
    logic [31:0] tick_r;
    logic [7:0]  bits_left_r;
    logic        saw_busy_r;
    logic        match_r;
    logic        sel_s;
    logic        grant_s;
    logic        load_tx_s;
    logic        load_rx_s;
    logic        expired_s;
    logic        tick_wrap_s;

    assign expired_s   = (bits_left_r == 8'd0);
    assign tick_wrap_s = (tick_r == (period_r - 32'd1));
    assign grant_s     = (state_r == ST_IDLE) && (state_nxt_s == ST_GRANT);

`ifdef MAN_LINK_ROUND_ROBIN_EN
    logic rr_ptr_r;

    // Round-robin pointer: prefer the source not granted last time.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_r <= 1'b0;
        end else if (grant_s) begin
            rr_ptr_r <= ~sel_s;
        end
    end

    // Source selection when leaving IDLE.
    always_comb begin
        sel_s = 1'b0;
        if (link.req0_valid && link.req1_valid) begin
            sel_s = rr_ptr_r;
        end else begin
            sel_s = link.req1_valid;
        end
    end
`else
    // Source selection when leaving IDLE: requester 0 always has priority.
    always_comb begin
        sel_s = 1'b0;
        if (link.req0_valid) begin
            sel_s = 1'b0;
        end else begin
            sel_s = link.req1_valid;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic and timer load strobes.
    always_comb begin
        state_nxt_s = state_r;
        load_tx_s   = 1'b0;
        load_rx_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (link.req0_valid || link.req1_valid) begin
                    state_nxt_s = ST_GRANT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                state_nxt_s = ST_START;
                load_tx_s   = 1'b1;
            end
            ST_START: begin
                state_nxt_s = ST_TX_WAIT;
            end
            ST_TX_WAIT: begin
                // Busy never rose within the start window: counts as a failed attempt.
                if (saw_busy_r && !link.enc_busy) begin
                    state_nxt_s = ST_RX_WAIT;
                    load_rx_s   = 1'b1;
                end else if (!saw_busy_r && !link.enc_busy && expired_s) begin
                    state_nxt_s = ST_CHECK;
                end else begin
                    state_nxt_s = ST_TX_WAIT;
                end
            end
            ST_RX_WAIT: begin
                if (link.dec_valid || expired_s) begin
                    state_nxt_s = ST_CHECK;
                end else begin
                    state_nxt_s = ST_RX_WAIT;
                end
            end
            ST_CHECK: begin
                if (match_r) begin
                    state_nxt_s = ST_DONE;
                end else if (retry_cnt_r < MAX_RETRY_C) begin
                    state_nxt_s = ST_START;
                    load_tx_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_FAIL;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            ST_FAIL: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Bit-period timer: tick_r divides clk down to bit periods, bits_left_r counts periods.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_r      <= 32'd0;
            bits_left_r <= 8'd0;
        end else if (load_tx_s) begin
            tick_r      <= 32'd0;
            bits_left_r <= BUSY_WAIT_BITS_C;
        end else if (load_rx_s) begin
            tick_r      <= 32'd0;
            bits_left_r <= TIMEOUT_BITS_C;
        end else if (!expired_s) begin
            if (tick_wrap_s) begin
                tick_r      <= 32'd0;
                bits_left_r <= bits_left_r - 8'd1;
            end else begin
                tick_r <= tick_r + 32'd1;
            end
        end
    end

    // Per-attempt tracking: encoder busy seen, decoder result compare.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            saw_busy_r <= 1'b0;
            match_r    <= 1'b0;
        end else if (state_r == ST_START) begin
            saw_busy_r <= 1'b0;
            match_r    <= 1'b0;
        end else begin
            if ((state_r == ST_TX_WAIT) && link.enc_busy) begin
                saw_busy_r <= 1'b1;
            end
            if ((state_r == ST_RX_WAIT) && link.dec_valid) begin
                match_r <= (link.dec_data == enc_data_r);
            end
        end
    end

    // Grant latching, retry counting and registered pulse/status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enc_data_r   <= 8'd0;
            enc_start_r  <= 1'b0;
            req0_ready_r <= 1'b0;
            req1_ready_r <= 1'b0;
            done_ok_r    <= 1'b0;
            done_err_r   <= 1'b0;
            grant_src_r  <= 1'b0;
            retry_cnt_r  <= 2'd0;
            err_count_r  <= 8'd0;
            period_r     <= 32'd1;
        end else begin
            req0_ready_r <= grant_s && !sel_s;
            req1_ready_r <= grant_s && sel_s;
            enc_start_r  <= (state_nxt_s == ST_START);
            done_ok_r    <= (state_nxt_s == ST_DONE);
            done_err_r   <= (state_nxt_s == ST_FAIL);
            if (grant_s) begin
                grant_src_r <= sel_s;
                enc_data_r  <= sel_s ? link.req1_data : link.req0_data;
                period_r    <= (divide_freq == 32'd0) ? 32'd1 : divide_freq;
                retry_cnt_r <= 2'd0;
            end else if ((state_r == ST_CHECK) && (state_nxt_s == ST_START)) begin
                retry_cnt_r <= retry_cnt_r + 2'd1;
            end
            if ((state_nxt_s == ST_FAIL) && (state_r != ST_FAIL) && (err_count_r != 8'd255)) begin
                err_count_r <= err_count_r + 8'd1;
            end
        end
    end

    assign link.enc_data   = enc_data_r;
    assign link.enc_start  = enc_start_r;
    assign link.req0_ready = req0_ready_r;
    assign link.req1_ready = req1_ready_r;
    assign done_ok         = done_ok_r;
    assign done_err        = done_err_r;
    assign grant_src       = grant_src_r;
    assign retry_cnt       = retry_cnt_r;
    assign err_count       = err_count_r;
    assign state_out       = state_r;
endmodule

// File: tb/tb_man_link_scheduler.sv
// Scoreboard bench for man_link_scheduler: requesters, encoder/decoder model and a
// transaction-level reference model of the retry/arbitration rules.
module tb_man_link_scheduler;
    localparam int MAX_RETRY = 3;

    typedef struct {
        logic [7:0] data;
        int         k;      // number of leading failed attempts
        int         mode;   // failure kind: 0 wrong byte, 1 decoder silent, 2 encoder never busy
    } txn_t;

    typedef struct {
        logic       src;
        logic [7:0] data;
        logic       ok;
        logic [1:0] retries;
        int         starts;
        logic [7:0] errs;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] divide_freq;
    logic        done_ok;
    logic        done_err;
    logic        grant_src;
    logic [1:0]  retry_cnt;
    logic [7:0]  err_count;
    logic [2:0]  state_out;

    man_link_scheduler_if link ();

    man_link_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .link       (link),
        .divide_freq(divide_freq),
        .done_ok    (done_ok),
        .done_err   (done_err),
        .grant_src  (grant_src),
        .retry_cnt  (retry_cnt),
        .err_count  (err_count),
        .state_out  (state_out)
    );

    always #5 clk = ~clk;

    txn_t q0[$];
    txn_t q1[$];
    txn_t cur;
    exp_t sb[$];
    int   attempt   = 0;
    int   n_vec     = 0;
    int   n_err     = 0;
    int   model_err = 0;
    int   last_src  = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: outcome of one byte follows directly from its failed-attempt count.
    task automatic issue(input bit src, input logic [7:0] data, input int k, input int mode);
        txn_t t;
        exp_t e;
        t.data = data;
        t.k    = k;
        t.mode = mode;
        e.src     = src;
        e.data    = data;
        e.ok      = (k <= MAX_RETRY);
        e.retries = e.ok ? 2'(k) : 2'(MAX_RETRY);
        e.starts  = int'(e.retries) + 1;
        if (!e.ok && model_err < 255) model_err++;
        e.errs = 8'(model_err);
        sb.push_back(e);
        if (src) q1.push_back(t);
        else     q0.push_back(t);
        last_src = int'(src);
    endtask

    task automatic drain(input int max_cycles);
        int n = 0;
        while (sb.size() != 0 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", sb.size(), 0);
        if (sb.size() != 0) begin
            sb.delete();
            q0.delete();
            q1.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    // Requesters: present the queue head, pop it when its ready pulse is seen.
    initial begin
        link.req0_valid = 1'b0;
        link.req0_data  = 8'd0;
        link.req1_valid = 1'b0;
        link.req1_data  = 8'd0;
        forever begin
            @(negedge clk);
            if (link.req0_ready === 1'b1 && q0.size() > 0) begin
                cur     = q0.pop_front();
                attempt = 0;
            end
            if (link.req1_ready === 1'b1 && q1.size() > 0) begin
                cur     = q1.pop_front();
                attempt = 0;
            end
            link.req0_valid = (q0.size() > 0);
            link.req0_data  = (q0.size() > 0) ? q0[0].data : 8'd0;
            link.req1_valid = (q1.size() > 0);
            link.req1_data  = (q1.size() > 0) ? q1[0].data : 8'd0;
        end
    end

    task automatic run_attempt();
        bit fail;
        int d;
        int b;
        int r;
        fail = (attempt < cur.k);
        attempt++;
        if (fail && cur.mode == 2) return;
        d = int'($urandom_range(1, 2));
        repeat (d) @(negedge clk);
        link.enc_busy = 1'b1;
        b = int'($urandom_range(1, 6));
        for (int i = 0; i < b; i++) begin
            @(negedge clk);
            if (fail && i == 0 && b >= 2) begin
                link.dec_valid = 1'b1;   // stray result while transmitting must be ignored
                link.dec_data  = cur.data;
            end else begin
                link.dec_valid = 1'b0;
            end
        end
        link.dec_valid = 1'b0;
        link.enc_busy  = 1'b0;
        if (fail && cur.mode == 1) return;
        r = int'($urandom_range(1, 5));
        repeat (r) @(negedge clk);
        link.dec_valid = 1'b1;
        link.dec_data  = fail ? (cur.data ^ 8'($urandom_range(1, 255))) : cur.data;
        @(negedge clk);
        link.dec_valid = 1'b0;
    endtask

    // Encoder/decoder loopback model.
    initial begin
        link.enc_busy  = 1'b0;
        link.dec_valid = 1'b0;
        link.dec_data  = 8'd0;
        forever begin
            @(negedge clk);
            if (link.enc_start === 1'b1) run_attempt();
        end
    end

    // Monitor: compare every completed transfer with the scoreboard head.
    initial begin
        int   starts   = 0;
        bit   chk_idle = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (chk_idle) begin
                chk("state_idle_after_done", 32'(state_out), 32'd0);
                chk_idle = 1'b0;
            end
            if (link.req0_ready === 1'b1 || link.req1_ready === 1'b1) starts = 0;
            if (link.enc_start === 1'b1) starts++;
            if (done_ok === 1'b1 || done_err === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'({done_ok, done_err}), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("outcome", 32'({done_ok, done_err}), e.ok ? 32'd2 : 32'd1);
                    chk("grant_src", 32'(grant_src), 32'(e.src));
                    chk("enc_data", 32'(link.enc_data), 32'(e.data));
                    chk("retry_cnt", 32'(retry_cnt), 32'(e.retries));
                    chk("enc_starts", 32'(starts), 32'(e.starts));
                    chk("err_count", 32'(err_count), 32'(e.errs));
                    chk_idle = 1'b1;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t t;
        int   n;
        int   pref;
        rst         = 1'b0;
        divide_freq = 32'd4;
        repeat (3) @(negedge clk);
        chk("rst_state", 32'(state_out), 32'd0);
        chk("rst_enc_data", 32'(link.enc_data), 32'd0);
        chk("rst_enc_start", 32'(link.enc_start), 32'd0);
        chk("rst_ready", 32'({link.req0_ready, link.req1_ready}), 32'd0);
        chk("rst_done", 32'({done_ok, done_err}), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        issue(1'b0, 8'hA5, 0, 0);                 // clean echo
        drain(2000);
        issue(1'b0, 8'h3C, 2, 0);                 // two wrong results, then match
        drain(2000);
        issue(1'b0, 8'h81, 5, 1);                 // decoder silent: four attempts then fail
        drain(3000);
        issue(1'b1, 8'h42, 1, 2);                 // encoder never busy on the first attempt
        drain(2000);

        for (int i = 0; i < 40; i++) begin
            divide_freq = 32'($urandom_range(0, 4));
            @(posedge clk);
            issue(1'($urandom_range(0, 1)), 8'($urandom), int'($urandom_range(0, 5)),
                  int'($urandom_range(0, 2)));
            drain(3000);
        end

        // Both requesters loaded at once: grant order comes from the arbitration rule.
        divide_freq = 32'd2;
        @(posedge clk);
`ifdef MAN_LINK_ROUND_ROBIN_EN
        pref = (last_src == 0) ? 1 : 0;
        for (int i = 0; i < 8; i++) begin
            issue(1'((pref + i) % 2), 8'($urandom), int'($urandom_range(0, 3)), 0);
        end
`else
        pref = 0;
        for (int i = 0; i < 8; i++) begin
            issue(1'(i / 4), 8'($urandom), int'($urandom_range(0, 3)), 0);
        end
`endif
        drain(8000);

        // Reset while waiting on the decoder: no completion, outputs cleared at once.
        divide_freq = 32'd3;
        @(posedge clk);
        t.data = 8'h55;
        t.k    = 5;
        t.mode = 1;
        q0.push_back(t);
        n = 0;
        while (state_out != 3'd4 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("reach_rx_wait", 32'(state_out), 32'd4);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_state", 32'(state_out), 32'd0);
        chk("arst_enc_data", 32'(link.enc_data), 32'd0);
        chk("arst_grant_src", 32'(grant_src), 32'd0);
        chk("arst_retry_cnt", 32'(retry_cnt), 32'd0);
        chk("arst_err_count", 32'(err_count), 32'd0);
        chk("arst_done", 32'({done_ok, done_err, link.enc_start}), 32'd0);
        repeat (3) @(negedge clk);
        rst       = 1'b1;
        model_err = 0;
        last_src  = -1;
        repeat (2) @(negedge clk);
        issue(1'b1, 8'h5A, 0, 0);
        drain(2000);

        // Saturate the failure counter.
        divide_freq = 32'd1;
        @(posedge clk);
        for (int i = 0; i < 256; i++) begin
            issue(1'b0, 8'($urandom), 4, (i % 2 == 0) ? 0 : 2);
        end
        drain(40000);
        chk("err_count_saturated", 32'(err_count), 32'd255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/man_link_scheduler.md
Name: man_link_scheduler

Overview:
- Sequences the Manchester encoder/decoder loop. Arbitrates byte-transfer requests from two sources: requester 0 is the button-driven DIP data path; requester 1 is the auto/test pattern source.
- Per granted byte: issues one encoder start, waits for transmission to finish, waits for the decoder result with a bit-period-scaled timeout, compares the result against the sent byte, and retries on mismatch or timeout.
- Sits between the data_input/transfer buttons and the Man_encoder/Man_decoder pair. Status outputs feed the LED/digitron multiplexing.

Parameters:
- MAX_RETRY, 3, retries after the first attempt before a byte is declared failed (0..3).
- TIMEOUT_BITS, 24, bit periods to wait for dec_valid after enc_busy falls.

Ports:
- clk  input  1  system clock, single domain.
- rst  input  1  asynchronous, active-low reset.
- req0_valid  input  1  requester 0 has a byte.
- req0_data  input  8  requester 0 byte.
- req0_ready  output  1  1-cycle pulse: req0 byte accepted.
- req1_valid  input  1  requester 1 has a byte.
- req1_data  input  8  requester 1 byte.
- req1_ready  output  1  1-cycle pulse: req1 byte accepted.
- divide_freq  input  32  clk cycles per Manchester bit period; sampled at grant.
- enc_data  output  8  byte presented to the encoder; held stable from START through RX_WAIT.
- enc_start  output  1  1-cycle encoder start pulse.
- enc_busy  input  1  encoder transmitting.
- dec_valid  input  1  1-cycle pulse: decoder byte ready.
- dec_data  input  8  decoded byte.
- done_ok  output  1  1-cycle pulse: byte verified.
- done_err  output  1  1-cycle pulse: byte failed after all retries.
- grant_src  output  1  source of the current/last transfer.
- retry_cnt  output  2  retries used on the current/last byte.
- err_count  output  8  failed bytes since reset; saturates at 255.
- state_out  output  3  FSM state encoding, for LD display.

Behaviour:
- Reset (rst=0, async): FSM=IDLE. Outputs: enc_data=0, enc_start=0, req*_ready=0, done_ok=0, done_err=0, grant_src=0, retry_cnt=0, err_count=0, state_out=0. Internal counters cleared.
- State encodings: IDLE=0, GRANT=1, START=2, TX_WAIT=3, RX_WAIT=4, CHECK=5, DONE=6, FAIL=7.
- IDLE: if any req*_valid, go to GRANT.
- GRANT (1 cycle):
  - Select a source (see Optional Feature); pulse that source's req*_ready.
  - Latch its data into enc_data; latch divide_freq (a value of 0 is treated as 1).
  - Set grant_src; clear retry_cnt; go to START.
- START (1 cycle): enc_start=1; go to TX_WAIT.
- TX_WAIT:
  - Wait for an enc_busy rising edge, then its falling edge.
  - If enc_busy is never seen high within 4 bit periods of START, treat as timeout.
  - On the falling edge: load the timeout counter with TIMEOUT_BITS x bit period (nested counters, no multiplier); go to RX_WAIT.
- RX_WAIT:
  - dec_valid: capture dec_data; go to CHECK.
  - Counter expiry: treat as mismatch; go to CHECK.
  - dec_valid in the same cycle as expiry: dec_valid wins.
- CHECK (1 cycle):
  - Match: go to DONE.
  - Mismatch or timeout with retry_cnt < MAX_RETRY: increment retry_cnt; go to START. Same data, no new grant.
  - Otherwise: go to FAIL.
- DONE: done_ok pulse for 1 cycle; go to IDLE.
- FAIL: done_err pulse for 1 cycle; err_count += 1 (saturating); go to IDLE.
- dec_valid outside RX_WAIT is ignored.
- req*_valid is never sampled outside IDLE/GRANT. A requester must hold valid until its ready pulse.
- Back-to-back requests: at least one IDLE cycle between transfers.
- Async reset mid-transfer aborts the transfer immediately. No done pulse is issued; the in-flight byte is dropped.

Optional Feature:
- Macro: MAN_LINK_ROUND_ROBIN_EN.
- Defined: round-robin arbitration. When both requesters are valid, grant the source opposite to the last grant_src. After reset, req0 wins first.
- Undefined: fixed priority. req0 always wins when both are valid; the pointer logic is absent.

Test Plan:
- Single req0 byte 0xA5, divide_freq=4, loopback model echoes the byte: req0_ready pulses once, enc_data=0xA5, one enc_start, done_ok=1, retry_cnt=0, err_count=0.
- Decoder model returns 0x00 for the first 2 attempts, then 0x3C (sent 0x3C): 3 enc_start pulses, retry_cnt=2, done_ok once, done_err never.
- Decoder never asserts dec_valid, MAX_RETRY=3: 4 enc_start pulses, then done_err once; err_count=1. Timeout per attempt = 24 x divide_freq cycles after enc_busy falls.
- req0 and req1 both held valid for 4 transfers:
  - With MAX_RETRY... round-robin (MAN_LINK_ROUND_ROBIN_EN defined): grant order 0,1,0,1.
  - Without the macro: order 0,0,0,0 while req0 stays valid.
- Assert rst=0 during RX_WAIT: all outputs return to reset values asynchronously; no done pulse. A subsequent req1 byte 0x5A completes normally with grant_src=1.
- Force 256 failed bytes: err_count saturates at 255; state_out returns to 0 after each failure.
